div_issue_queue: RTL and testbench
==================================

DIV_ISSUE_QUEUE -- requirements
Module: div_issue_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of queue entries (power of two, 2..8).
REQ-002 Parameter TAG_W, default 6: ROB/physical tag width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 dispatch_en  input  1  dispatch a divide instruction this cycle.
REQ-006 dispatch_rsdata / dispatch_rtdata  input  16 each  operand values (valid only when matching ready bit set).
REQ-007 dispatch_rsready / dispatch_rtready  input  1 each  operand value present.
REQ-008 dispatch_rstag / dispatch_rttag  input  TAG_W each  producer tags for pending operands.
REQ-009 dispatch_rdtag  input  TAG_W  destination tag.
REQ-010 cdb_valid  input  1; cdb_tag  input  TAG_W; cdb_data  input  32: common data bus broadcast.
REQ-011 div_busy  input  1  divider cannot accept an operation this cycle.
REQ-012 flush  input  1  discard all queued entries (mispredict recovery).
REQ-013 queue_full  output  1  all DEPTH entries valid.
REQ-014 queue_count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-015 issue_enable  output  1  one-cycle pulse: operands presented to divider.
REQ-016 issue_rsdata / issue_rtdata  output  16 each; issue_rdtag  output  TAG_W: issued operation.

Function
REQ-017 Entries are age-ordered, slot 0 oldest; an entry holds valid, rs/rt data, rs/rt ready, rs/rt tags, rdtag.
REQ-018 Dispatch with dispatch_en=1 and queue_full=0 writes the new entry into the lowest free slot at the next edge; dispatch while queue_full=1 is dropped, no state change.
REQ-019 CDB snoop: each valid entry with an operand not ready and tag == cdb_tag while cdb_valid=1 captures cdb_data[15:0] and sets that ready bit at the edge; both operands may capture in the same cycle.
REQ-020 An entry is eligible when valid and both ready bits set at the start of the cycle (no same-cycle CDB-to-issue bypass).
REQ-021 Selection: lowest-index eligible entry; when div_busy=0 and an eligible entry exists, issue_enable=1 and issue_* registered from that entry at the edge, entry removed.
REQ-022 Issue outputs are registered: issue_enable high exactly one cycle per issue; issue_* hold last issued values when issue_enable=0.
REQ-023 Removal compacts: entries above the issued slot shift down one slot in the same edge, preserving age order and in-flight CDB captures.
REQ-024 Simultaneous issue and dispatch: both occur; new entry lands in the lowest free slot after compaction; queue_full evaluated from pre-edge state.
REQ-025 div_busy=1: no issue; entries retained; snoop and dispatch continue.
REQ-026 flush=1: all valid bits cleared and issue_enable=0 at next edge; flush has priority over dispatch, issue and snoop in that cycle.
REQ-027 Minimum latency: dispatch with both operands ready at edge N -> issue_enable=1 after edge N+1.
REQ-028 queue_count and queue_full are combinational from registered valid bits.

Reset
REQ-029 reset=0 asynchronously clears all valid bits, issue_enable=0, issue_rsdata/rtdata=16'h0, issue_rdtag=0; queue_count=0, queue_full=0.
REQ-030 Reset mid-operation discards all entries including partially captured operands; no issue in the first cycle after release.

Configuration
REQ-031 Macro DIVQ_DISPATCH_BYPASS_EN defined: an operand dispatched not ready whose tag matches a same-cycle cdb_valid broadcast is written ready with cdb_data[15:0].
REQ-032 Macro undefined: dispatched operand is stored exactly as presented; a same-cycle matching broadcast is not captured (dispatcher responsible for forwarding).

Structure
REQ-033 Shared package holds DATA_W=16, TAG_W default, DEPTH default, and the queue entry typedef.
REQ-034 One sub-module divq_entry: single slot storage plus CDB tag compare and capture; top holds selection, compaction, issue registers.

Verification
REQ-035 Dispatch rs=100, rt=7 both ready, rdtag=5, div_busy=0 -> issue_enable pulse one cycle later with 100/7/5; queue_count back to 0.
REQ-036 Dispatch rt pending tag 9; CDB tag 9 data 32'h0003 two cycles later -> entry issues the cycle after capture with rt=3.
REQ-037 Fill 4 entries, div_busy=1 -> queue_full=1, fifth dispatch dropped; release busy -> issues in age order 0,1,2,3.
REQ-038 Entry 0 pending, entry 1 ready -> entry 1 issues first; entry 0 shifts/remains, issues after its CDB capture.
REQ-039 Full queue with issue and dispatch same cycle -> dispatch dropped, count 3; flush with dispatch_en=1 -> count 0, no issue.
REQ-040 With DIVQ_DISPATCH_BYPASS_EN: dispatch rs tag 12 while CDB tag 12 data 40 -> issues rs=40; without macro the entry stays pending.

Source files
------------

// File: rtl/div_issue_queue_pkg.sv
// Shared types and defaults for the divide issue queue: entry layout and the
// CDB capture rule used both by stored slots and by the optional dispatch bypass.
package div_issue_queue_pkg;

    localparam int DATA_W     = 16;
    localparam int DIVQ_TAG_W = 6;
    localparam int DIVQ_DEPTH = 4;
    // Tags are held at a fixed maximum width so one entry type serves any TAG_W <= 16.
    localparam int TAG_MAX_W  = 16;

    typedef struct packed {
        logic                 valid;
        logic                 rs_ready;
        logic                 rt_ready;
        logic [DATA_W-1:0]    rs_data;
        logic [DATA_W-1:0]    rt_data;
        logic [TAG_MAX_W-1:0] rs_tag;
        logic [TAG_MAX_W-1:0] rt_tag;
        logic [TAG_MAX_W-1:0] rd_tag;
    } divq_entry_t;

    function automatic divq_entry_t divq_capture(
        input divq_entry_t          e,
        input logic                 cdb_valid,
        input logic [TAG_MAX_W-1:0] cdb_tag,
        input logic [31:0]          cdb_data
    );
        divq_entry_t r;
        r = e;
        if (e.valid && cdb_valid) begin
            if (!e.rs_ready && (e.rs_tag == cdb_tag)) begin
                r.rs_ready = 1'b1;
                r.rs_data  = cdb_data[DATA_W-1:0];
            end
            if (!e.rt_ready && (e.rt_tag == cdb_tag)) begin
                r.rt_ready = 1'b1;
                r.rt_data  = cdb_data[DATA_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/div_issue_queue_entry.sv
// One queue slot: registered entry plus the CDB-snooped view of it that the
// top uses as next state, whether the entry stays put or shifts down a slot.
module divq_entry
    import div_issue_queue_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_i,
    input  logic                 cdb_valid_i,
    input  logic [TAG_MAX_W-1:0] cdb_tag_i,
    input  logic [31:0]          cdb_data_i,
    input  divq_entry_t          load_i,
    output divq_entry_t          entry_o,
    output divq_entry_t          snoop_o
);

    divq_entry_t entry_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry_q <= '0;
        end else if (flush_i) begin
            entry_q <= '0;
        end else begin
            entry_q <= load_i;
        end
    end

    assign entry_o = entry_q;
    assign snoop_o = divq_capture(entry_q, cdb_valid_i, cdb_tag_i, cdb_data_i);

endmodule

// File: rtl/div_issue_queue.sv
// Age-ordered, compacting issue queue for the divider (slot 0 oldest).
// Define DIVQ_DISPATCH_BYPASS_EN to capture a same-cycle CDB result into a dispatching entry.
module div_issue_queue
    import div_issue_queue_pkg::*;
#(
    parameter int DEPTH = DIVQ_DEPTH,
    parameter int TAG_W = DIVQ_TAG_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dispatch_en,
    input  logic [DATA_W-1:0]     dispatch_rsdata,
    input  logic [DATA_W-1:0]     dispatch_rtdata,
    input  logic                  dispatch_rsready,
    input  logic                  dispatch_rtready,
    input  logic [TAG_W-1:0]      dispatch_rstag,
    input  logic [TAG_W-1:0]      dispatch_rttag,
    input  logic [TAG_W-1:0]      dispatch_rdtag,
    input  logic                  cdb_valid,
    input  logic [TAG_W-1:0]      cdb_tag,
    input  logic [31:0]           cdb_data,
    input  logic                  div_busy,
    input  logic                  flush,
    output logic                  queue_full,
    output logic [$clog2(DEPTH):0] queue_count,
    output logic                  issue_enable,
    output logic [DATA_W-1:0]     issue_rsdata,
    output logic [DATA_W-1:0]     issue_rtdata,
    output logic [TAG_W-1:0]      issue_rdtag
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);

    divq_entry_t          slot_q  [DEPTH];
    divq_entry_t          snoop_w [DEPTH];
    divq_entry_t          disp_entry;
    logic [DEPTH-1:0]     valid_w;
    logic [DEPTH-1:0]     elig_w;
    logic                 any_elig;
    logic                 issue_fire;
    logic [IDX_W-1:0]     issue_idx;
    logic [CNT_W-1:0]     count_w;
    logic [CNT_W-1:0]     fill_idx;
    logic                 disp_accept;
    logic [TAG_MAX_W-1:0] cdb_tag_ext;

    logic                 issue_enable_q;
    logic [DATA_W-1:0]    issue_rsdata_q;
    logic [DATA_W-1:0]    issue_rtdata_q;
    logic [TAG_W-1:0]     issue_rdtag_q;

    assign cdb_tag_ext = TAG_MAX_W'(cdb_tag);

    always_comb begin
        count_w = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_w = count_w + CNT_W'(valid_w[i]);
        end
    end

    assign queue_count = count_w;
    assign queue_full  = (count_w == CNT_W'(DEPTH));

    // Eligibility looks only at registered ready bits, so a CDB capture issues a cycle later.
    always_comb begin
        any_elig  = 1'b0;
        issue_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (elig_w[i]) begin
                any_elig  = 1'b1;
                issue_idx = IDX_W'(i);
            end
        end
    end

    assign issue_fire  = any_elig && !div_busy && !flush;
    assign disp_accept = dispatch_en && !queue_full && !flush;
    // Valid entries stay contiguous, so the lowest free slot after compaction is the new count.
    assign fill_idx    = count_w - CNT_W'(issue_fire);

    always_comb begin
        disp_entry          = '0;
        disp_entry.valid    = 1'b1;
        disp_entry.rs_ready = dispatch_rsready;
        disp_entry.rt_ready = dispatch_rtready;
        disp_entry.rs_data  = dispatch_rsdata;
        disp_entry.rt_data  = dispatch_rtdata;
        disp_entry.rs_tag   = TAG_MAX_W'(dispatch_rstag);
        disp_entry.rt_tag   = TAG_MAX_W'(dispatch_rttag);
        disp_entry.rd_tag   = TAG_MAX_W'(dispatch_rdtag);
`ifdef DIVQ_DISPATCH_BYPASS_EN
        disp_entry = divq_capture(disp_entry, cdb_valid, cdb_tag_ext, cdb_data);
`endif
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        divq_entry_t shift_src;
        divq_entry_t load_d;

        if (gi < DEPTH - 1) begin : g_mid
            assign shift_src = snoop_w[gi+1];
        end else begin : g_top
            assign shift_src = '0;
        end

        always_comb begin
            load_d = snoop_w[gi];
            if (issue_fire && (int'(issue_idx) <= gi)) begin
                load_d = shift_src;
            end
            if (disp_accept && (fill_idx == CNT_W'(gi))) begin
                load_d = disp_entry;
            end
        end

        assign valid_w[gi] = slot_q[gi].valid;
        assign elig_w[gi]  = slot_q[gi].valid && slot_q[gi].rs_ready && slot_q[gi].rt_ready;

        divq_entry u_entry (
            .clk         (clk),
            .reset       (reset),
            .flush_i     (flush),
            .cdb_valid_i (cdb_valid),
            .cdb_tag_i   (cdb_tag_ext),
            .cdb_data_i  (cdb_data),
            .load_i      (load_d),
            .entry_o     (slot_q[gi]),
            .snoop_o     (snoop_w[gi])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_enable_q <= 1'b0;
            issue_rsdata_q <= '0;
            issue_rtdata_q <= '0;
            issue_rdtag_q  <= '0;
        end else begin
            issue_enable_q <= issue_fire;
            if (issue_fire) begin
                issue_rsdata_q <= slot_q[issue_idx].rs_data;
                issue_rtdata_q <= slot_q[issue_idx].rt_data;
                issue_rdtag_q  <= slot_q[issue_idx].rd_tag[TAG_W-1:0];
            end
        end
    end

    assign issue_enable = issue_enable_q;
    assign issue_rsdata = issue_rsdata_q;
    assign issue_rtdata = issue_rtdata_q;
    assign issue_rdtag  = issue_rdtag_q;

endmodule

// File: tb/tb_div_issue_queue.sv
// Bench for div_issue_queue: directed scenarios plus random traffic, all checked
// each cycle against a queue-based model; honours DIVQ_DISPATCH_BYPASS_EN.
module tb_div_issue_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              dispatch_en;
    logic [15:0]       dispatch_rsdata, dispatch_rtdata;
    logic              dispatch_rsready, dispatch_rtready;
    logic [TAG_W-1:0]  dispatch_rstag, dispatch_rttag, dispatch_rdtag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [31:0]       cdb_data;
    logic              div_busy;
    logic              flush;
    logic              queue_full;
    logic [2:0]        queue_count;
    logic              issue_enable;
    logic [15:0]       issue_rsdata, issue_rtdata;
    logic [TAG_W-1:0]  issue_rdtag;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0]      rs, rt;
        logic             rsr, rtr;
        logic [TAG_W-1:0] rst, rtt, rdt;
    } m_ent_t;

    m_ent_t           mq[$];
    logic             m_ie;
    logic [15:0]      m_rs, m_rt;
    logic [TAG_W-1:0] m_rd;

    div_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .dispatch_en      (dispatch_en),
        .dispatch_rsdata  (dispatch_rsdata),
        .dispatch_rtdata  (dispatch_rtdata),
        .dispatch_rsready (dispatch_rsready),
        .dispatch_rtready (dispatch_rtready),
        .dispatch_rstag   (dispatch_rstag),
        .dispatch_rttag   (dispatch_rttag),
        .dispatch_rdtag   (dispatch_rdtag),
        .cdb_valid        (cdb_valid),
        .cdb_tag          (cdb_tag),
        .cdb_data         (cdb_data),
        .div_busy         (div_busy),
        .flush            (flush),
        .queue_full       (queue_full),
        .queue_count      (queue_count),
        .issue_enable     (issue_enable),
        .issue_rsdata     (issue_rsdata),
        .issue_rtdata     (issue_rtdata),
        .issue_rdtag      (issue_rdtag)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("count", 32'(queue_count), 32'(mq.size()));
        chk("full", 32'(queue_full), 32'(mq.size() == DEPTH));
        chk("issue_enable", 32'(issue_enable), 32'(m_ie));
        chk("issue_rsdata", 32'(issue_rsdata), 32'(m_rs));
        chk("issue_rtdata", 32'(issue_rtdata), 32'(m_rt));
        chk("issue_rdtag", 32'(issue_rdtag), 32'(m_rd));
    endtask

    task automatic model_reset();
        mq.delete();
        m_ie = 1'b0;
        m_rs = '0;
        m_rt = '0;
        m_rd = '0;
    endtask

    function automatic m_ent_t snoop(input m_ent_t e);
        m_ent_t r;
        r = e;
        if (cdb_valid && !e.rsr && e.rst == cdb_tag) begin r.rsr = 1'b1; r.rs = cdb_data[15:0]; end
        if (cdb_valid && !e.rtr && e.rtt == cdb_tag) begin r.rtr = 1'b1; r.rt = cdb_data[15:0]; end
        return r;
    endfunction

    // Next state from the current inputs: issue oldest ready entry, snoop, then append dispatch.
    task automatic model_step();
        int     idx;
        logic   was_full;
        m_ent_t e;
        if (flush) begin
            mq.delete();
            m_ie = 1'b0;
            return;
        end
        was_full = (mq.size() == DEPTH);
        idx = -1;
        for (int i = 0; i < mq.size(); i++)
            if (idx < 0 && mq[i].rsr && mq[i].rtr) idx = i;
        m_ie = 1'b0;
        if (idx >= 0 && !div_busy) begin
            m_ie = 1'b1;
            m_rs = mq[idx].rs;
            m_rt = mq[idx].rt;
            m_rd = mq[idx].rdt;
        end
        for (int i = 0; i < mq.size(); i++) mq[i] = snoop(mq[i]);
        if (m_ie) mq.delete(idx);
        if (dispatch_en && !was_full) begin
            e.rs  = dispatch_rsdata;  e.rt  = dispatch_rtdata;
            e.rsr = dispatch_rsready; e.rtr = dispatch_rtready;
            e.rst = dispatch_rstag;   e.rtt = dispatch_rttag;
            e.rdt = dispatch_rdtag;
`ifdef DIVQ_DISPATCH_BYPASS_EN
            e = snoop(e);
`endif
            mq.push_back(e);
        end
    endtask

    task automatic idle();
        dispatch_en = 1'b0;
        dispatch_rsdata = '0; dispatch_rtdata = '0;
        dispatch_rsready = 1'b0; dispatch_rtready = 1'b0;
        dispatch_rstag = '0; dispatch_rttag = '0; dispatch_rdtag = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        div_busy = 1'b0;
        flush = 1'b0;
    endtask

    task automatic disp(input logic [15:0] rs, input logic rsr, input logic [TAG_W-1:0] rst,
                        input logic [15:0] rt, input logic rtr, input logic [TAG_W-1:0] rtt,
                        input logic [TAG_W-1:0] rd);
        dispatch_en = 1'b1;
        dispatch_rsdata = rs; dispatch_rsready = rsr; dispatch_rstag = rst;
        dispatch_rtdata = rt; dispatch_rtready = rtr; dispatch_rttag = rtt;
        dispatch_rdtag = rd;
    endtask

    task automatic tick(input string what);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_model();
        $display("cycle %s: count=%0d full=%0d ie=%0d rs=%0d rt=%0d rd=%0d", what,
                 queue_count, queue_full, issue_enable, issue_rsdata, issue_rtdata, issue_rdtag);
        idle();
    endtask

    initial begin
        reset = 1'b0;
        idle();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_count", 32'(queue_count), 0);
        chk("reset_full", 32'(queue_full), 0);
        chk("reset_ie", 32'(issue_enable), 0);
        chk("reset_rs", 32'(issue_rsdata), 0);
        chk("reset_rd", 32'(issue_rdtag), 0);
        reset = 1'b1;

        // Ready dispatch issues one edge after it lands
        disp(16'd100, 1'b1, 6'd0, 16'd7, 1'b1, 6'd0, 6'd5);
        tick("t1_dispatch");
        chk("t1_count1", 32'(queue_count), 1);
        chk("t1_no_issue_yet", 32'(issue_enable), 0);
        tick("t1_issue");
        chk("t1_ie", 32'(issue_enable), 1);
        chk("t1_rs", 32'(issue_rsdata), 100);
        chk("t1_rt", 32'(issue_rtdata), 7);
        chk("t1_rd", 32'(issue_rdtag), 5);
        chk("t1_count0", 32'(queue_count), 0);
        tick("t1_after");
        chk("t1_pulse_ends", 32'(issue_enable), 0);
        chk("t1_hold_rs", 32'(issue_rsdata), 100);

        // Pending rt captured from CDB, issues the cycle after capture
        disp(16'd20, 1'b1, 6'd0, 16'd0, 1'b0, 6'd9, 6'd6);
        tick("t2_dispatch");
        tick("t2_wait");
        cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'h0000_0003;
        tick("t2_capture");
        chk("t2_no_bypass_issue", 32'(issue_enable), 0);
        tick("t2_issue");
        chk("t2_ie", 32'(issue_enable), 1);
        chk("t2_rt", 32'(issue_rtdata), 3);
        chk("t2_rd", 32'(issue_rdtag), 6);

        // Fill while busy, fifth dropped, then drain in age order
        for (int i = 0; i < 5; i++) begin
            div_busy = 1'b1;
            disp(16'(i + 1), 1'b1, 6'd0, 16'd2, 1'b1, 6'd0, 6'(10 + i));
            tick("t3_fill");
        end
        chk("t3_full", 32'(queue_full), 1);
        chk("t3_count", 32'(queue_count), 4);
        for (int i = 0; i < 4; i++) begin
            tick("t3_drain");
            chk("t3_order", 32'(issue_rdtag), 32'(10 + i));
        end
        chk("t3_empty", 32'(queue_count), 0);

        // Younger ready entry overtakes an older pending one
        disp(16'd0, 1'b0, 6'd20, 16'd4, 1'b1, 6'd0, 6'd1);
        tick("t4_old_pending");
        disp(16'd8, 1'b1, 6'd0, 16'd2, 1'b1, 6'd0, 6'd2);
        tick("t4_young_ready");
        tick("t4_young_issue");
        chk("t4_first_rd", 32'(issue_rdtag), 2);
        cdb_valid = 1'b1; cdb_tag = 6'd20; cdb_data = 32'd55;
        tick("t4_capture");
        tick("t4_old_issue");
        chk("t4_second_ie", 32'(issue_enable), 1);
        chk("t4_second_rd", 32'(issue_rdtag), 1);
        chk("t4_second_rs", 32'(issue_rsdata), 55);

        // Full queue: issue and dispatch together drops dispatch; flush beats everything
        for (int i = 0; i < 4; i++) begin
            div_busy = 1'b1;
            disp(16'd9, 1'b1, 6'd0, 16'd3, 1'b1, 6'd0, 6'(30 + i));
            tick("t5_fill");
        end
        disp(16'd9, 1'b1, 6'd0, 16'd3, 1'b1, 6'd0, 6'd34);
        tick("t5_issue_and_drop");
        chk("t5_count3", 32'(queue_count), 3);
        chk("t5_rd", 32'(issue_rdtag), 30);
        flush = 1'b1;
        disp(16'd9, 1'b1, 6'd0, 16'd3, 1'b1, 6'd0, 6'd35);
        tick("t5_flush");
        chk("t5_flush_count", 32'(queue_count), 0);
        chk("t5_flush_ie", 32'(issue_enable), 0);

        // Same-cycle CDB broadcast at dispatch
        disp(16'd0, 1'b0, 6'd12, 16'd5, 1'b1, 6'd0, 6'd7);
        cdb_valid = 1'b1; cdb_tag = 6'd12; cdb_data = 32'd40;
        tick("t6_dispatch_cdb");
        tick("t6_next");
`ifdef DIVQ_DISPATCH_BYPASS_EN
        chk("t6_bypass_ie", 32'(issue_enable), 1);
        chk("t6_bypass_rs", 32'(issue_rsdata), 40);
`else
        chk("t6_pending_ie", 32'(issue_enable), 0);
        chk("t6_pending_count", 32'(queue_count), 1);
        flush = 1'b1;
        tick("t6_cleanup");
`endif

        // Asynchronous reset mid-operation
        disp(16'd1, 1'b0, 6'd3, 16'd1, 1'b1, 6'd0, 6'd8);
        tick("t7_load");
        #2 reset = 1'b0;
        #1;
        chk("t7_async_count", 32'(queue_count), 0);
        chk("t7_async_ie", 32'(issue_enable), 0);
        chk("t7_async_rs", 32'(issue_rsdata), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 6'd3; cdb_data = 32'd77;
        tick("t7_after_release");
        chk("t7_no_issue", 32'(issue_enable), 0);

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            dispatch_en      = ($urandom_range(0, 99) < 60);
            dispatch_rsdata  = 16'($urandom);
            dispatch_rtdata  = 16'($urandom);
            dispatch_rsready = ($urandom_range(0, 99) < 60);
            dispatch_rtready = ($urandom_range(0, 99) < 60);
            dispatch_rstag   = 6'($urandom_range(0, 7));
            dispatch_rttag   = 6'($urandom_range(0, 7));
            dispatch_rdtag   = 6'($urandom);
            cdb_valid        = ($urandom_range(0, 99) < 40);
            cdb_tag          = 6'($urandom_range(0, 7));
            cdb_data         = $urandom;
            div_busy         = ($urandom_range(0, 99) < 30);
            flush            = ($urandom_range(0, 99) < 2);
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
